// File: rtl/slow_clk_monitor.sv
// Slow-clock receiver: synchronizes i_slow_clk into i_clk, emits tick strobes, measures period, tracks lock/loss.
// Optional: define SLOW_CLK_BOTH_EDGE_EN to also tick on synchronized falling edges.
//
// state   | meaning
// ACQUIRE | after reset, waiting for the first rising tick
// MEASURE | measuring periods, counting consecutive good ones
// LOCKED  | LOCK_CNT good periods seen, watching for bad period/timeout
// LOST    | no rising tick for TIMEOUT cycles, counter parked
module slow_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 24,
  parameter int EXP_PERIOD  = 1_250_000,
  parameter int TOL         = 1_250,
  parameter int TIMEOUT     = 1_500_000,
  parameter int LOCK_CNT    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_slow_clk,
  input  logic             i_clr_err,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_lock,
  output logic             o_lost,
  output logic [7:0]       o_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  CNT_TO    = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_MEASURE,
    ST_LOCKED,
    ST_LOST
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   rise_q;
  logic [CNT_W-1:0]       count;
  logic [GOOD_W-1:0]      good;
  logic                   period_ok;
  logic                   timeout;
  logic                   err_inc;

`ifdef SLOW_CLK_BOTH_EDGE_EN
  logic fall_q;
`endif

  // Edge strobes are registered once more so the FSM acts in the same cycle o_tick is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      rise_q <= 1'b0;
      o_tick <= 1'b0;
`ifdef SLOW_CLK_BOTH_EDGE_EN
      fall_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_slow_clk};
      sync_d <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~sync_d;
`ifdef SLOW_CLK_BOTH_EDGE_EN
      fall_q <= ~sync_q[SYNC_STAGES-1] & sync_d;
      o_tick <= rise_q | fall_q;
`else
      o_tick <= rise_q;
`endif
    end
  end

  always_comb begin
    period_ok = (count >= PER_MIN) && (count <= PER_MAX);
    timeout   = (count == CNT_TO) && !rise_q;
    err_inc   = (state == ST_LOCKED) && ((rise_q && !period_ok) || timeout);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_ACQUIRE;
      count        <= '0;
      good         <= '0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_lock       <= 1'b0;
      o_lost       <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      o_period_vld <= 1'b0;

      if (rise_q)
        count <= CNT_W'(1);
      else if (count != CNT_TO)
        count <= count + CNT_W'(1);

      case (state)
        ST_ACQUIRE: begin
          if (rise_q) begin
            state <= ST_MEASURE;
            good  <= '0;
          end else if (timeout) begin
            state  <= ST_LOST;
            o_lost <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise_q) begin
            o_period     <= count;
            o_period_vld <= 1'b1;
            if (period_ok) begin
              good <= good + GOOD_W'(1);
              if (good == GOOD_LAST) begin
                state  <= ST_LOCKED;
                o_lock <= 1'b1;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            state  <= ST_LOST;
            o_lost <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (rise_q) begin
            o_period     <= count;
            o_period_vld <= 1'b1;
            if (!period_ok) begin
              state  <= ST_MEASURE;
              good   <= '0;
              o_lock <= 1'b0;
            end
          end else if (timeout) begin
            state  <= ST_LOST;
            o_lock <= 1'b0;
            o_lost <= 1'b1;
          end
        end
        ST_LOST: begin
          if (rise_q) begin
            state  <= ST_MEASURE;
            good   <= '0;
            o_lost <= 1'b0;
          end
        end
        default: begin
          state  <= ST_ACQUIRE;
          o_lock <= 1'b0;
          o_lost <= 1'b0;
        end
      endcase

      if (i_clr_err)
        o_err_cnt <= '0;
      else if (err_inc && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Randomized bench for slow_clk_monitor, checked every cycle against an event-level reference model.
module tb_slow_clk_monitor;
  localparam int EXP = 20;
  localparam int TOL = 1;
  localparam int TO  = 40;
  localparam int LCK = 4;
  localparam int SS  = 2;
  localparam int CW  = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_slow_clk;
  logic          i_clr_err;
  logic          o_tick;
  logic [CW-1:0] o_period;
  logic          o_period_vld;
  logic          o_lock;
  logic          o_lost;
  logic [7:0]    o_err_cnt;

  always #5 i_clk = ~i_clk;

  slow_clk_monitor #(
    .SYNC_STAGES(SS), .CNT_W(CW), .EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TO), .LOCK_CNT(LCK)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_slow_clk(i_slow_clk), .i_clr_err(i_clr_err),
    .o_tick(o_tick), .o_period(o_period), .o_period_vld(o_period_vld),
    .o_lock(o_lock), .o_lost(o_lost), .o_err_cnt(o_err_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: samples of i_slow_clk taken at each posedge, newest in bit 0.
  logic [3:0] m_hist;
  int         m_age;
  int         m_mode;   // 0 acquire, 1 measure, 2 locked, 3 lost
  int         m_good;
  int         m_err;
  int         m_period;
  logic       m_tick;
  logic       m_vld;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = '0; m_age = 0; m_mode = 0; m_good = 0; m_err = 0;
    m_period = 0; m_tick = 1'b0; m_vld = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic c);
    logic rise, fall, inc;
    rise = m_hist[SS] & ~m_hist[SS+1];
    fall = ~m_hist[SS] & m_hist[SS+1];
    m_hist = {m_hist[2:0], s};
`ifdef SLOW_CLK_BOTH_EDGE_EN
    m_tick = rise | fall;
`else
    m_tick = rise;
`endif
    m_vld = 1'b0;
    inc = 1'b0;
    if (rise) begin
      if (m_mode == 1 || m_mode == 2) begin
        m_period = m_age;
        m_vld = 1'b1;
        if (m_age >= EXP - TOL && m_age <= EXP + TOL) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LCK) m_mode = 2;
          end
        end else begin
          if (m_mode == 2) inc = 1'b1;
          m_mode = 1;
          m_good = 0;
        end
      end else begin
        m_mode = 1;
        m_good = 0;
      end
      m_age = 1;
    end else begin
      if (m_age == TO && m_mode != 3) begin
        if (m_mode == 2) inc = 1'b1;
        m_mode = 3;
      end
      if (m_age < TO) m_age++;
    end
    if (c) m_err = 0;
    else if (inc && m_err < 255) m_err++;
  endtask

  task automatic check_all();
    chk("tick",   int'(o_tick),       int'(m_tick));
    chk("vld",    int'(o_period_vld), int'(m_vld));
    chk("period", int'(o_period),     m_period);
    chk("lock",   int'(o_lock),       (m_mode == 2) ? 1 : 0);
    chk("lost",   int'(o_lost),       (m_mode == 3) ? 1 : 0);
    chk("err",    int'(o_err_cnt),    m_err);
  endtask

  task automatic step(input logic s, input logic c);
    @(negedge i_clk);
    i_slow_clk = s;
    i_clr_err  = c;
    @(posedge i_clk);
    if (i_reset) model_reset();
    else model_step(s, c);
    #1;
    check_all();
  endtask

  function automatic logic pick_clr(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return ($urandom_range(0, 63) == 0);
    return 1'b0;
  endfunction

  task automatic wave(input int p, input int clr_mode);
    for (int i = 0; i < p; i++)
      step((i < p / 2) ? 1'b1 : 1'b0, pick_clr(clr_mode));
  endtask

  task automatic hold_low(input int n, input int clr_mode);
    for (int i = 0; i < n; i++) step(1'b0, pick_clr(clr_mode));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    int p;
    i_reset = 1'b1; i_slow_clk = 1'b0; i_clr_err = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // lock on nominal square wave
    hold_low(5, 0);
    for (int i = 0; i < 5; i++) wave(EXP, 0);
    chk("lock_after_5_rises", int'(o_lock), 1);

    // one long period while locked, then relock
    wave(25, 0);
    for (int i = 0; i < 5; i++) wave(EXP, 0);
    chk("err_after_bad", int'(o_err_cnt), 1);
    chk("relock", int'(o_lock), 1);

    // stop the slow clock while locked, then resume
    hold_low(60, 0);
    chk("lost_after_hold", int'(o_lost), 1);
    chk("err_after_loss", int'(o_err_cnt), 2);
    for (int i = 0; i < 6; i++) wave(EXP, 0);

    // clear coinciding with a lock-loss increment
    wave(25, 1);
    wave(EXP, 1);
    chk("clr_wins", int'(o_err_cnt), 0);

    // reset in the middle of a locked period
    for (int i = 0; i < 5; i++) wave(EXP, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 6; i++) wave(EXP, 0);

    // randomized periods, stalls, clears and occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) hold_low($urandom_range(30, 50), 2);
      else if ($urandom_range(0, 49) == 0) do_reset($urandom_range(0, 3));
      else begin
        p = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : EXP;
        wave(p, 2);
      end
    end

    // saturation of the error counter
    do_reset(1);
    wave(EXP, 0);
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < LCK; j++) wave(EXP, 0);
      wave(25, 0);
    end
    wave(EXP, 0);
    chk("err_saturated", int'(o_err_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
